// File: rtl/polymul_pkg.sv
// Shared types and index helper for the negacyclic streaming polynomial multiplier.
package polymul_pkg;

    // Input side: load coefficients, run the MAC schedule, hand off to the output buffer.
    typedef enum logic [1:0] {
        StLoad,
        StCalc,
        StXfer
    } in_state_t;

    // Output side: buffer empty, or streaming a finished result.
    typedef enum logic {
        StEmpty,
        StDrain
    } out_state_t;

    // u index feeding a lane at a given step, and whether the term wraps past x^N.
    typedef struct packed {
        logic [31:0] idx;
        logic        sub;
    } nc_sel_t;

    // Lane j at step t consumes u[(j - t) mod N]; wrapped terms are negated since x^N = -1.
    function automatic nc_sel_t nc_idx(input int unsigned j, input int unsigned t,
                                       input int unsigned n);
        nc_sel_t r;
        if (j >= t) begin
            r.idx = j - t;
            r.sub = 1'b0;
        end else begin
            r.idx = j + n - t;
            r.sub = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/polymul_mac_lane.sv
// One accumulator lane: acc +/-= ext(u_sel) * p_t, all arithmetic mod 2^QW.
module polymul_mac_lane
    import polymul_pkg::*;
#(
    parameter int unsigned QW       = 64,
    parameter int unsigned UW       = 2,
    parameter bit          U_SIGNED = 1'b1,
    parameter int unsigned LANE     = 0
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [QW-1:0] i_p_t,
    input  logic [UW-1:0] i_u_sel,
    input  logic          i_sub,
    output logic [QW-1:0] o_acc
);

    logic [QW-1:0] r_acc;
    logic [QW-1:0] w_u_ext;
    logic [QW-1:0] w_prod;

    // Sign- or zero-extend u, then form the truncated product.
    always_comb begin
        w_u_ext = {{(QW-UW){U_SIGNED & i_u_sel[UW-1]}}, i_u_sel};
        w_prod  = w_u_ext * i_p_t;
    end

    // Accumulator: cleared on hand-off to the output buffer, updated during CALC.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_sub ? (r_acc - w_prod) : (r_acc + w_prod);
        end
    end

    // Clear and accumulate belong to different input FSM states and never coincide.
    always_ff @(posedge clk) begin
        if (s_rst_n) begin
            assert (!(i_clr && i_en))
            else $error("mac lane %0d: clr and en both high", LANE);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/polymul_negacyclic_stream.sv
// Streaming negacyclic multiplier z = p*u in Z_(2^QW)[x]/(x^N+1), N parallel MAC lanes,
// double-buffered so the next load overlaps the previous result's drain.
module polymul_negacyclic_stream
    import polymul_pkg::*;
#(
    parameter int unsigned N        = 16,
    parameter int unsigned QW       = 64,
    parameter int unsigned UW       = 2,
    parameter bit          U_SIGNED = 1'b1
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic [QW-1:0] i_p_data,
    input  logic          i_p_vld,
    output logic          o_p_rdy,
    input  logic          i_p_last,
    input  logic [UW-1:0] i_u_data,
    input  logic          i_u_vld,
    output logic          o_u_rdy,
    input  logic          i_u_last,
    output logic [QW-1:0] o_z_data,
    output logic          o_z_vld,
    input  logic          i_z_rdy,
    output logic          o_z_last,
    output logic          o_len_err
);

    localparam int unsigned   IW      = $clog2(N);
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    in_state_t     r_in_state;
    in_state_t     w_in_state_nxt;
    out_state_t    r_out_state;
    out_state_t    w_out_state_nxt;

    logic          r_rdy;
    logic [IW-1:0] r_k;
    logic [IW-1:0] r_t;
    logic [IW-1:0] r_i;
    logic          r_len_err;
    logic [QW-1:0] r_p_mem [N];
    logic [UW-1:0] r_u_mem [N];
    logic [QW-1:0] r_obuf  [N];

    logic          w_accept;
    logic          w_last_in;
    logic          w_load_done;
    logic          w_xfer;
    logic          w_calc_en;
    logic          w_z_hs;
    logic [QW-1:0] w_p_t;
    nc_sel_t       w_sel   [N];
    logic [UW-1:0] w_u_sel [N];
    logic [N-1:0]  w_sub;
    logic [QW-1:0] w_acc   [N];

    // Input FSM next state; rdy is a registered copy of "next state is LOAD".
    always_comb begin
        w_in_state_nxt = r_in_state;
        w_accept       = 1'b0;
        w_load_done    = 1'b0;
        w_xfer         = 1'b0;
        w_last_in      = i_p_last | i_u_last;
        unique case (r_in_state)
            StLoad: begin
                w_accept    = r_rdy & i_p_vld & i_u_vld;
                w_load_done = w_accept & (w_last_in | (r_k == LastIdx));
                if (w_load_done) begin
                    w_in_state_nxt = StCalc;
                end
            end
            StCalc: begin
                if (r_t == LastIdx) begin
                    w_in_state_nxt = StXfer;
                end
            end
            StXfer: begin
                // Registered EMPTY: the copy lands one cycle after a drain finishes.
                w_xfer = (r_out_state == StEmpty);
                if (w_xfer) begin
                    w_in_state_nxt = StLoad;
                end
            end
            default: w_in_state_nxt = StLoad;
        endcase
    end

    assign w_calc_en = (r_in_state == StCalc);

    // Input state, coefficient memories, load/step counters and sticky length error.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_in_state <= StLoad;
            r_rdy      <= 1'b0;
            r_k        <= '0;
            r_t        <= '0;
            r_len_err  <= 1'b0;
            for (int m = 0; m < N; m++) begin
                r_p_mem[m] <= '0;
                r_u_mem[m] <= '0;
            end
        end else begin
            r_in_state <= w_in_state_nxt;
            r_rdy      <= (w_in_state_nxt == StLoad);
            if (w_accept) begin
                r_p_mem[r_k] <= i_p_data;
                r_u_mem[r_k] <= i_u_data;
                r_k          <= r_k + 1'b1;
                // last must coincide exactly with the N-th beat
                if (w_last_in != (r_k == LastIdx)) begin
                    r_len_err <= 1'b1;
                end
            end
            if (w_load_done) begin
                r_k <= '0;
                r_t <= '0;
            end
            if (w_calc_en) begin
                r_t <= r_t + 1'b1;
            end
            // Unfilled slots of a short load must read as zero.
            if (w_xfer) begin
                for (int m = 0; m < N; m++) begin
                    r_p_mem[m] <= '0;
                    r_u_mem[m] <= '0;
                end
            end
        end
    end

    // Per-lane u mux and subtract flag; p_mem[t] is broadcast to every lane.
    always_comb begin
        w_p_t = r_p_mem[r_t];
        for (int j = 0; j < N; j++) begin
            w_sel[j]   = nc_idx(unsigned'(j), 32'(r_t), N);
            w_u_sel[j] = r_u_mem[IW'(w_sel[j].idx)];
            w_sub[j]   = w_sel[j].sub;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        polymul_mac_lane #(
            .QW       (QW),
            .UW       (UW),
            .U_SIGNED (U_SIGNED),
            .LANE     (j)
        ) u_lane (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .i_clr   (w_xfer),
            .i_en    (w_calc_en),
            .i_p_t   (w_p_t),
            .i_u_sel (w_u_sel[j]),
            .i_sub   (w_sub[j]),
            .o_acc   (w_acc[j])
        );
    end

    // Output FSM next state and the z handshake.
    always_comb begin
        w_out_state_nxt = r_out_state;
        w_z_hs          = 1'b0;
        unique case (r_out_state)
            StEmpty: begin
                if (w_xfer) begin
                    w_out_state_nxt = StDrain;
                end
            end
            StDrain: begin
                w_z_hs = i_z_rdy;
                if (w_z_hs && (r_i == LastIdx)) begin
                    w_out_state_nxt = StEmpty;
                end
            end
            default: w_out_state_nxt = StEmpty;
        endcase
    end

    // Output buffer, drain index and output state.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_out_state <= StEmpty;
            r_i         <= '0;
            for (int m = 0; m < N; m++) begin
                r_obuf[m] <= '0;
            end
        end else begin
            r_out_state <= w_out_state_nxt;
            if (w_xfer) begin
                r_i <= '0;
                for (int m = 0; m < N; m++) begin
                    r_obuf[m] <= w_acc[m];
                end
            end else if (w_z_hs) begin
                r_i <= r_i + 1'b1;
            end
        end
    end

    // Outputs come straight from registers, so they hold while z is stalled.
    always_comb begin
        o_p_rdy   = r_rdy;
        o_u_rdy   = r_rdy;
        o_z_vld   = (r_out_state == StDrain);
        o_z_data  = o_z_vld ? r_obuf[r_i] : '0;
        o_z_last  = o_z_vld && (r_i == LastIdx);
        o_len_err = r_len_err;
    end

endmodule

// File: tb/tb_polymul_negacyclic_stream.sv
// Directed bench: N=4, QW=8, UW=2; signed-u DUT plus an unsigned-u twin on shared stimulus.
module tb_polymul_negacyclic_stream;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       s_rst_n;
    logic [7:0] p_data;
    logic       p_vld, p_last;
    logic [1:0] u_data;
    logic       u_vld, u_last;
    logic       z_rdy;
    logic       p_rdy, u_rdy, z_vld, z_last, len_err;
    logic [7:0] z_data;
    logic       p_rdy2, u_rdy2, z_vld2, z_last2, len_err2;
    logic [7:0] z_data2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    polymul_negacyclic_stream #(.N(4), .QW(8), .UW(2), .U_SIGNED(1'b1)) dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .i_p_data(p_data), .i_p_vld(p_vld), .o_p_rdy(p_rdy), .i_p_last(p_last),
        .i_u_data(u_data), .i_u_vld(u_vld), .o_u_rdy(u_rdy), .i_u_last(u_last),
        .o_z_data(z_data), .o_z_vld(z_vld), .i_z_rdy(z_rdy), .o_z_last(z_last),
        .o_len_err(len_err)
    );

    polymul_negacyclic_stream #(.N(4), .QW(8), .UW(2), .U_SIGNED(1'b0)) dut_u (
        .clk(clk), .s_rst_n(s_rst_n),
        .i_p_data(p_data), .i_p_vld(p_vld), .o_p_rdy(p_rdy2), .i_p_last(p_last),
        .i_u_data(u_data), .i_u_vld(u_vld), .o_u_rdy(u_rdy2), .i_u_last(u_last),
        .o_z_data(z_data2), .o_z_vld(z_vld2), .i_z_rdy(z_rdy), .o_z_last(z_last2),
        .o_len_err(len_err2)
    );

    typedef struct {
        logic [3:0][7:0] p;
        logic [3:0][1:0] u;
        int              last_at;
        logic [3:0][7:0] z_s;
        logic [3:0][7:0] z_u;
        logic            err;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [3:0][7:0] v8(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][7:0] r;
        r[0] = 8'(a0);
        r[1] = 8'(a1);
        r[2] = 8'(a2);
        r[3] = 8'(a3);
        return r;
    endfunction

    function automatic logic [3:0][1:0] v2(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][1:0] r;
        r[0] = 2'(a0);
        r[1] = 2'(a1);
        r[2] = 2'(a2);
        r[3] = 2'(a3);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send nb beats; last goes on beat last_at (on u.last when via_u, else on p.last).
    task automatic send(input logic [3:0][7:0] p, input logic [3:0][1:0] u, input int nb,
                        input int last_at, input bit via_u);
        for (int k = 0; k < nb; k++) begin
            int wc;
            p_vld  = 1'b1;
            u_vld  = 1'b1;
            p_data = p[k];
            u_data = u[k];
            p_last = !via_u && (k == last_at);
            u_last = via_u && (k == last_at);
            wc = 0;
            while (p_rdy !== 1'b1 && wc < 200) begin
                step();
                wc++;
            end
            if (wc >= 200) begin
                check("send rdy timeout", 32'(p_rdy), 32'd1);
            end
            step();
        end
        p_vld  = 1'b0;
        u_vld  = 1'b0;
        p_last = 1'b0;
        u_last = 1'b0;
    endtask

    // Collect N beats with z.rdy following a 4-cycle pattern; checks every valid cycle.
    task automatic recv(input string tag, input logic [3:0][7:0] zs, input logic [3:0][7:0] zu,
                        input logic [3:0] pat);
        int i;
        int c;
        i = 0;
        c = 0;
        while (i < N && c < 300) begin
            z_rdy = pat[c % 4];
            if (z_vld) begin
                check({tag, " z_data"}, 32'(z_data), 32'(zs[i]));
                check({tag, " z_data unsigned"}, 32'(z_data2), 32'(zu[i]));
                check({tag, " z_last"}, 32'(z_last), 32'(i == N - 1));
                if (z_rdy) i++;
            end
            step();
            c++;
        end
        z_rdy = 1'b0;
        if (i < N) begin
            check({tag, " drain timeout beats"}, 32'(i), 32'(N));
        end
    endtask

    initial begin
        s_rst_n = 1'b0;
        p_data  = '0;
        p_vld   = 1'b0;
        p_last  = 1'b0;
        u_data  = '0;
        u_vld   = 1'b0;
        u_last  = 1'b0;
        z_rdy   = 1'b0;

        vecs[0] = '{p: v8(1, 2, 3, 4), u: v2(1, 0, 0, 0), last_at: 3,
                    z_s: v8(1, 2, 3, 4), z_u: v8(1, 2, 3, 4), err: 1'b0};
        vecs[1] = '{p: v8(1, 2, 3, 4), u: v2(0, 1, 0, 0), last_at: 3,
                    z_s: v8(252, 1, 2, 3), z_u: v8(252, 1, 2, 3), err: 1'b0};
        vecs[2] = '{p: v8(1, 2, 3, 4), u: v2(3, 0, 0, 0), last_at: 3,
                    z_s: v8(255, 254, 253, 252), z_u: v8(3, 6, 9, 12), err: 1'b0};
        vecs[3] = '{p: v8(10, 20, 30, 40), u: v2(1, 3, 0, 2), last_at: 3,
                    z_s: v8(90, 70, 90, 246), z_u: v8(106, 246, 10, 150), err: 1'b0};
        // N beats with no last: result still computed, length error raised
        vecs[4] = '{p: v8(7, 0, 0, 1), u: v2(1, 1, 0, 0), last_at: -1,
                    z_s: v8(6, 7, 0, 1), z_u: v8(6, 7, 0, 1), err: 1'b1};

        repeat (3) step();
        check("reset z_vld", 32'(z_vld), 32'd0);
        check("reset z_last", 32'(z_last), 32'd0);
        check("reset z_data", 32'(z_data), 32'd0);
        check("reset p_rdy", 32'(p_rdy), 32'd0);
        check("reset u_rdy", 32'(u_rdy), 32'd0);
        check("reset len_err", 32'(len_err), 32'd0);

        s_rst_n = 1'b1;
        check("rdy low before first edge", 32'(p_rdy), 32'd0);
        step();
        check("p_rdy after reset", 32'(p_rdy), 32'd1);
        check("u_rdy after reset", 32'(u_rdy), 32'd1);

        // Lone p.vld then lone u.vld must not load anything.
        p_vld  = 1'b1;
        p_data = 8'd99;
        repeat (2) step();
        p_vld  = 1'b0;
        u_vld  = 1'b1;
        u_data = 2'd3;
        repeat (2) step();
        u_vld  = 1'b0;

        for (int v = 0; v < 5; v++) begin
            send(vecs[v].p, vecs[v].u, N, vecs[v].last_at, 1'b0);
            check($sformatf("v%0d rdy low in calc", v), 32'(p_rdy), 32'd0);
            check($sformatf("v%0d z_vld low in calc", v), 32'(z_vld), 32'd0);
            repeat (N) step();
            check($sformatf("v%0d z_vld low in xfer", v), 32'(z_vld), 32'd0);
            step();
            check($sformatf("v%0d z_vld at T+N+2", v), 32'(z_vld), 32'd1);
            check($sformatf("v%0d rdy at T+N+2", v), 32'(p_rdy), 32'd1);
            recv($sformatf("v%0d", v), vecs[v].z_s, vecs[v].z_u, 4'b1111);
            check($sformatf("v%0d len_err", v), 32'(len_err), 32'(vecs[v].err));
            check($sformatf("v%0d len_err unsigned", v), 32'(len_err2), 32'(vecs[v].err));
        end

        // Backpressure 1,0,0,1: every stalled beat must hold its value.
        send(vecs[0].p, vecs[0].u, N, 3, 1'b0);
        recv("bp", vecs[0].z_s, vecs[0].z_u, 4'b1001);
        check("bp len_err sticky", 32'(len_err), 32'd1);

        // Back-to-back: second load overlaps the first drain.
        fork
            begin
                send(vecs[1].p, vecs[1].u, N, 3, 1'b0);
                send(vecs[3].p, vecs[3].u, N, 3, 1'b0);
            end
            begin
                recv("b2b first", vecs[1].z_s, vecs[1].z_u, 4'b1111);
                recv("b2b second", vecs[3].z_s, vecs[3].z_u, 4'b1111);
            end
        join
        check("b2b len_err sticky", 32'(len_err), 32'd1);

        // Reset to clear len_err, then a short load ended by u.last.
        s_rst_n = 1'b0;
        step();
        s_rst_n = 1'b1;
        step();
        check("len_err cleared by reset", 32'(len_err), 32'd0);
        send(v8(5, 6, 0, 0), v2(1, 0, 0, 0), 2, 1, 1'b1);
        check("short load len_err", 32'(len_err), 32'd1);
        begin
            int wc;
            wc = 0;
            while (z_vld !== 1'b1 && wc < 50) begin
                step();
                wc++;
            end
            check("short z_vld rises", 32'(z_vld), 32'd1);
        end
        z_rdy = 1'b1;
        check("short beat0", 32'(z_data), 32'd5);
        step();
        z_rdy = 1'b0;
        check("short beat1", 32'(z_data), 32'd6);
        step();
        check("short beat1 held", 32'(z_data), 32'd6);
        check("short no last yet", 32'(z_last), 32'd0);

        // Reset mid-drain discards the rest of the result.
        s_rst_n = 1'b0;
        step();
        check("mid-drain reset z_vld", 32'(z_vld), 32'd0);
        check("mid-drain reset z_last", 32'(z_last), 32'd0);
        check("mid-drain reset len_err", 32'(len_err), 32'd0);
        check("mid-drain reset p_rdy", 32'(p_rdy), 32'd0);
        s_rst_n = 1'b1;
        step();
        check("post reset p_rdy", 32'(p_rdy), 32'd1);
        check("post reset z_vld", 32'(z_vld), 32'd0);

        // A clean transaction after the reset: zeroed mems, no stale output.
        send(vecs[3].p, vecs[3].u, N, 3, 1'b0);
        recv("post reset", vecs[3].z_s, vecs[3].z_u, 4'b1111);
        check("post reset len_err", 32'(len_err), 32'd0);
        step();
        check("post reset idle z_vld", 32'(z_vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
